// File: rtl/led_trail_pwm_if.sv
// led_trail_pwm_if
//   Bundles the LED pattern, the trail enable and the PWM pin drive for the
//   afterglow stage.
//   led_i        : 8-bit pattern from the upstream scanner (master -> slave)
//   trail_en_i   : 1 = decaying trail, 0 = follow the input (master -> slave)
//   led_o        : PWM pin drive to the board LEDs (slave -> master)
//   decay_tick_o : one-cycle strobe on each decay step (slave -> master)
interface led_trail_pwm_if;
  logic [7:0] led_i;
  logic       trail_en_i;
  logic [7:0] led_o;
  logic       decay_tick_o;

  modport master (
    output led_i,
    output trail_en_i,
    input  led_o,
    input  decay_tick_o
  );

  modport slave (
    input  led_i,
    input  trail_en_i,
    output led_o,
    output decay_tick_o
  );
endinterface

// File: rtl/led_trail_pwm.sv
// led_trail_pwm
//   Turns each on/off bit of the scanner pattern into a PWM-dimmed pin drive
//   with a decaying afterglow, giving the comet-trail look.
//   clk_i : system clock (same as the upstream LED driver)
//   rst_i : asynchronous active-high reset, clears every fade immediately
//   bus   : led_trail_pwm_if.slave (led_i, trail_en_i in; led_o,
//           decay_tick_o out)
module led_trail_pwm #(
  parameter int   CLK_IN_MHZ   = 125,
  parameter logic LED_POLARITY = 1'b1,
  parameter logic IN_POLARITY  = 1'b1,
  parameter int   DECAY_MS     = 4,
  parameter int   DECAY_STEP   = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  led_trail_pwm_if.slave bus
);

  localparam int PRE_TC = CLK_IN_MHZ * 1000 - 1;
  localparam int PRE_W  = (PRE_TC > 0) ? $clog2(PRE_TC + 1) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic [7:0]       dec_cnt;
  logic [7:0]       pwm_cnt;
  logic [7:0]       led_q;
  logic [7:0]       level [8];
  logic [7:0]       lit;
  logic [7:0]       led_drv;
  logic             ms_tick;
  logic             decay_tick;

  assign ms_tick    = (pre_cnt == PRE_W'(PRE_TC));
  // Combinational so the strobe and the level decrement share the same cycle.
  assign decay_tick = ms_tick && (dec_cnt == 8'(DECAY_MS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_cnt <= '0;
      dec_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (ms_tick) begin
        pre_cnt <= '0;
        if (decay_tick)
          dec_cnt <= '0;
        else
          dec_cnt <= dec_cnt + 8'd1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  // led_q = 1 always means "on", whatever the upstream pin convention.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      led_q <= '0;
    else
      led_q <= bus.led_i ^ {8{~IN_POLARITY}};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < 8; n++)
        level[n] <= '0;
    end else begin
      for (int n = 0; n < 8; n++) begin
        if (led_q[n])
          level[n] <= 8'hFF;
        else if (!bus.trail_en_i)
          level[n] <= '0;
        else if (decay_tick) begin
          // Saturate at zero rather than wrapping.
          if (level[n] >= 8'(DECAY_STEP))
            level[n] <= level[n] - 8'(DECAY_STEP);
          else
            level[n] <= '0;
        end
      end
    end
  end

  // 255 is forced solid on; otherwise duty is level/256.
  always_comb begin
    lit = '0;
    for (int n = 0; n < 8; n++)
      lit[n] = (level[n] == 8'hFF) || (level[n] > pwm_cnt);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      led_drv <= {8{~LED_POLARITY}};
    else
      led_drv <= lit ^ {8{~LED_POLARITY}};
  end

  assign bus.led_o        = led_drv;
  assign bus.decay_tick_o = decay_tick;

endmodule

// File: tb/tb_led_trail_pwm.sv
module tb_led_trail_pwm;

  localparam int MHZ  = 1;
  localparam int DMS  = 1;
  localparam int STEP = 64;
  localparam int PRE  = MHZ * 1000;

  logic clk;
  logic rst;

  led_trail_pwm_if bus_a ();
  led_trail_pwm_if bus_b ();

  led_trail_pwm #(
    .CLK_IN_MHZ(MHZ), .LED_POLARITY(1'b1), .IN_POLARITY(1'b1),
    .DECAY_MS(DMS), .DECAY_STEP(STEP)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a)
  );

  led_trail_pwm #(
    .CLK_IN_MHZ(MHZ), .LED_POLARITY(1'b0), .IN_POLARITY(1'b0),
    .DECAY_MS(DMS), .DECAY_STEP(STEP)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: t = clock edges since reset release. Everything else
  // follows from the stated rules as plain arithmetic on t and the levels.
  int         t;
  logic [7:0] m_q   [2];
  int         m_lvl [2][8];
  logic [7:0] m_out [2];

  function automatic bit exp_tick(int tt);
    return ((tt % PRE) == PRE - 1) && (((tt / PRE) % DMS) == DMS - 1);
  endfunction

  function automatic int next_level(int lvl, bit on, bit trail, bit tick);
    if (on) return 255;
    if (!trail) return 0;
    if (tick) return (lvl - STEP < 0) ? 0 : lvl - STEP;
    return lvl;
  endfunction

  function automatic logic [7:0] lit_vec(int i, int pwm);
    logic [7:0] v;
    v = '0;
    for (int n = 0; n < 8; n++)
      v[n] = (m_lvl[i][n] == 255) || (m_lvl[i][n] > pwm);
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t <= 0;
      m_q[0] <= '0;
      m_q[1] <= '0;
      m_out[0] <= 8'h00;
      m_out[1] <= 8'hFF;
      for (int i = 0; i < 2; i++)
        for (int n = 0; n < 8; n++)
          m_lvl[i][n] <= 0;
    end else begin
      t <= t + 1;
      m_q[0] <= bus_a.led_i;
      m_q[1] <= ~bus_b.led_i;
      m_out[0] <= lit_vec(0, t % 256);
      m_out[1] <= ~lit_vec(1, t % 256);
      for (int i = 0; i < 2; i++)
        for (int n = 0; n < 8; n++)
          m_lvl[i][n] <= next_level(m_lvl[i][n], m_q[i][n], bus_a.trail_en_i, exp_tick(t));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_led_a", 32'(bus_a.led_o), 32'(m_out[0]));
      check("model_led_b", 32'(bus_b.led_o), 32'(m_out[1]));
      check("model_tick_a", 32'(bus_a.decay_tick_o), 32'(exp_tick(t)));
      check("model_tick_b", 32'(bus_b.decay_tick_o), 32'(exp_tick(t)));
    end
  end

  task automatic set_led(input logic [7:0] a, input logic [7:0] b);
    bus_a.led_i = a;
    bus_b.led_i = b;
  endtask

  task automatic set_trail(input logic en);
    bus_a.trail_en_i = en;
    bus_b.trail_en_i = en;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * PRE * DMS + 10; i++) begin
      @(negedge clk);
      if (bus_a.decay_tick_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_bit(input int bitn, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus_a.led_o[bitn]) cnt++;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cnt;
    int exp_lvl;
    bit found;

    rst = 1'b1;
    set_led(8'h00, 8'hFF);
    set_trail(1'b1);
    #1;
    check("rst_led_a", 32'(bus_a.led_o), 32'h00);
    check("rst_led_b", 32'(bus_b.led_o), 32'hFF);
    check("rst_tick_a", 32'(bus_a.decay_tick_o), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset release timing: first tick, then the period.
    set_led(8'hFF, 8'h00);
    k = 0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk);
      k++;
      #1;
      if (bus_a.decay_tick_o) break;
    end
    check("first_tick_edges", 32'(k), 32'(PRE - 1));
    k = 0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk);
      k++;
      #1;
      if (bus_a.decay_tick_o) break;
    end
    check("tick_period", 32'(k), 32'(PRE));

    // Mid-cycle asynchronous reset with every LED lit.
    repeat (5) @(posedge clk);
    check("pre_rst_lit_a", 32'(bus_a.led_o), 32'hFF);
    #3 rst = 1'b1;
    #1;
    check("async_rst_a", 32'(bus_a.led_o), 32'h00);
    check("async_rst_b", 32'(bus_b.led_o), 32'hFF);
    check("async_rst_tick", 32'(bus_a.decay_tick_o), 32'd0);
    set_led(8'h00, 8'hFF);
    @(negedge clk);
    rst = 1'b0;

    // Latency: three cycles from the edge to solid on.
    set_trail(1'b0);
    repeat (5) @(negedge clk);
    set_led(8'h01, 8'hFF);
    @(negedge clk);
    check("lat_1", 32'(bus_a.led_o), 32'h00);
    @(negedge clk);
    check("lat_2", 32'(bus_a.led_o), 32'h00);
    @(negedge clk);
    check("lat_3", 32'(bus_a.led_o), 32'h01);
    count_bit(0, 300, cnt);
    check("lat_solid", 32'(cnt), 32'd300);

    // Decay sequence on channel 0, duty measured per 256-cycle window.
    set_trail(1'b1);
    wait_tick();
    set_led(8'h00, 8'hFF);
    for (int s = 0; s < 5; s++) begin
      wait_tick();
      repeat (4) @(negedge clk);
      count_bit(0, 256, cnt);
      exp_lvl = 255 - STEP * (s + 1);
      if (exp_lvl < 0) exp_lvl = 0;
      check($sformatf("decay_duty_%0d", s), 32'(cnt), 32'(exp_lvl));
    end

    // Rising edge on channel 3 reaching the level stage on a tick cycle.
    set_led(8'h08, 8'hFF);
    wait_tick();
    set_led(8'h00, 8'hFF);
    wait_tick();
    found = 1'b0;
    for (int i = 0; i < PRE + 10; i++) begin
      @(negedge clk);
      if ((t % PRE) == PRE - 2) begin
        found = 1'b1;
        break;
      end
    end
    check("simul_found", 32'(found), 32'd1);
    set_led(8'h08, 8'hFF);
    @(negedge clk);
    check("simul_tick", 32'(bus_a.decay_tick_o), 32'd1);
    set_led(8'h00, 8'hFF);
    repeat (3) @(negedge clk);
    count_bit(3, 256, cnt);
    check("simul_solid", 32'(cnt), 32'd256);

    // Trail disabled: no fade.
    set_trail(1'b0);
    set_led(8'hFF, 8'hFF);
    repeat (5) @(negedge clk);
    set_led(8'h00, 8'hFF);
    repeat (3) @(negedge clk);
    check("notrail_off", 32'(bus_a.led_o), 32'h00);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (bus_a.led_o != 8'h00) cnt++;
    end
    check("notrail_dark", 32'(cnt), 32'd0);

    // Inverted polarity instance.
    set_led(8'h00, 8'hFE);
    repeat (4) @(negedge clk);
    check("pol_b", 32'(bus_b.led_o), 32'hFE);

    // Randomized segments, checked cycle by cycle against the model.
    for (int seg = 0; seg < 30; seg++) begin
      set_led(8'($urandom), 8'($urandom));
      set_trail($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 600)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        set_led(8'h00, 8'hFF);
        set_trail(1'b1);
        repeat ($urandom_range(200, 1500)) @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
